// File: rtl/seg_view_pkg.sv
// Shared constants for the seven-segment view controller:
// window limits, special digit codes and the segment glyph table.
package seg_view_pkg;

    localparam logic [1:0] VIEW_MIN = 2'b00;
    localparam logic [1:0] VIEW_MAX = 2'b10;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_e;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        SEG_OFF,  // F
        SEG_OFF,  // E
        SEG_OFF,  // D
        SEG_OFF,  // C
        SEG_OFF,  // B
        7'h3F,    // A: minus
        7'h10,    // 9
        7'h00,    // 8
        7'h78,    // 7
        7'h02,    // 6
        7'h12,    // 5
        7'h19,    // 4
        7'h30,    // 3
        7'h24,    // 2
        7'h79,    // 1
        7'h40     // 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        return SEG_LUT[code];
    endfunction

endpackage

// File: rtl/seg_view_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= btn;
            sync <= meta;
            db_d <= db;
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = db & ~db_d;

endmodule

// File: rtl/seg_view_ctrl.sv
// Scroll-button view register and four-digit multiplexed scanner
// for the active-low seven-segment display.
module seg_view_ctrl
    import seg_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_DIV     = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [3:0] disp0,
    input  logic [3:0] disp1,
    input  logic [3:0] disp2,
    input  logic [3:0] disp3,
    output logic [1:0] view_mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic          press_l;
    logic          press_r;
    step_e         step;
    logic [1:0]    view_next;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [3:0]    code;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_left),
        .press(press_l)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_right),
        .press(press_r)
    );

    // Simultaneous presses cancel out.
    always_comb begin
        step = STEP_NONE;
        unique case (1'b1)
            press_l & ~press_r: step = STEP_UP;
            press_r & ~press_l: step = STEP_DOWN;
            default:            step = STEP_NONE;
        endcase
    end

    always_comb begin
        view_next = view_mode;
        unique case (step)
            STEP_UP: begin
                if (view_mode != VIEW_MAX) view_next = view_mode + 2'd1;
            end
            STEP_DOWN: begin
                if (view_mode != VIEW_MIN) view_next = view_mode - 2'd1;
            end
            default: view_next = view_mode;
        endcase
    end

    always_comb begin
        code = CODE_BLANK;
        unique case (idx)
            2'd0: code = disp0;
            2'd1: code = disp1;
            2'd2: code = disp2;
            2'd3: code = disp3;
            default: code = CODE_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            view_mode <= VIEW_MIN;
            ref_cnt   <= '0;
            idx       <= 2'd0;
            an        <= 4'b1111;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            view_mode <= view_next;
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_decode(code);
            // Decimal point on the rightmost digit marks a shifted window.
            dp  <= ~((idx == 2'd0) && (view_mode != VIEW_MIN));
        end
    end

endmodule

// File: tb/tb_seg_view_ctrl.sv
// Randomized scoreboard bench for seg_view_ctrl against a
// window-based behavioural model of debounce, view and scan.
module tb_seg_view_ctrl;

    localparam int D = 4;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [3:0] disp0 = 4'd1;
    logic [3:0] disp1 = 4'd2;
    logic [3:0] disp2 = 4'd3;
    logic [3:0] disp3 = 4'd4;
    logic [1:0] view_mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_view_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REFRESH_DIV    (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .disp0    (disp0),
        .disp1    (disp1),
        .disp2    (disp2),
        .disp3    (disp3),
        .view_mode(view_mode),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] vm;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit hist[2][D+2];
    bit db[2];
    bit rose[2];
    int m_vm = 0;
    int m_t = 0;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs after the coming edge, from the inputs now driven.
    task automatic model_edge();
        exp_t       e;
        bit         raw[2];
        int         idx;
        logic [3:0] code;
        bit         all_diff;
        raw[0] = btn_left;
        raw[1] = btn_right;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b0;
                db[b] = 1'b0;
                rose[b] = 1'b0;
            end
            m_vm = 0;
            m_t = 0;
            e = '{vm: 2'b00, an: 4'b1111, seg: 7'h7F, dp: 1'b1};
        end else begin
            idx = (m_t / R) % 4;
            case (idx)
                0:       code = disp0;
                1:       code = disp1;
                2:       code = disp2;
                default: code = disp3;
            endcase
            e.an = 4'hF ^ (4'd1 << idx);
            e.seg = glyph(code);
            e.dp = !(idx == 0 && m_vm != 0);
            if (rose[0] && !rose[1]) m_vm = (m_vm < 2) ? m_vm + 1 : 2;
            else if (rose[1] && !rose[0]) m_vm = (m_vm > 0) ? m_vm - 1 : 0;
            e.vm = 2'(m_vm);
            // Debounced level flips once the last D synchronized samples all disagree.
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < D + 1; i++) hist[b][i] = hist[b][i+1];
                hist[b][D+1] = raw[b];
                all_diff = 1'b1;
                for (int i = 0; i < D; i++)
                    if (hist[b][i] == db[b]) all_diff = 1'b0;
                rose[b] = 1'b0;
                if (all_diff) begin
                    db[b] = !db[b];
                    rose[b] = db[b];
                end
            end
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit bl, input bit br);
        rst_n = rst;
        btn_left = bl;
        btn_right = br;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit bl, input bit br);
        repeat (n) cyc(1'b1, bl, br);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every registered output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("view_mode", view_mode, e.vm);
                chk("an", an, e.an);
                chk("seg", seg, e.seg);
                chk("dp", dp, e.dp);
            end
        end
    end

    initial begin
        bit bl;
        bit br;
        bl = 1'b0;
        br = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        run(14, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        repeat (2) begin
            run(8, 1'b1, 1'b0);
            run(8, 1'b0, 1'b0);
        end
        repeat (3) begin
            run(8, 1'b0, 1'b1);
            run(8, 1'b0, 1'b0);
        end
        run(8, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        run(8, 1'b1, 1'b1);
        run(8, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        disp3 = 4'hA;
        disp2 = 4'hF;
        run(8, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        run(16, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        run(20, 1'b0, 1'b0);
        repeat (1500) begin
            if ($urandom_range(0, 4) == 0) bl = !bl;
            if ($urandom_range(0, 4) == 0) br = !br;
            if ($urandom_range(0, 7) == 0) disp0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) disp1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) disp2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) disp3 = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 199) != 0, bl, br);
        end
        run(4, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_view_ctrl.md
# seg_view_ctrl

Sequencing and scan controller for the four-digit seven-segment display fed by the BCD view stage. It debounces the two scroll buttons and owns the `view_mode` register (window selection 00/01/10) driven back into the BCD view stage. It time-multiplexes the four selected digit codes onto the shared active-low segment/anode bus. All outputs are registered.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized button level must differ from the debounced state before it is accepted; must be ≥2.
- `REFRESH_DIV`, 100000: cycles each digit stays lit; must be ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `btn_left`  in  1  raw asynchronous button; scrolls the window toward more-significant digits.
- `btn_right`  in  1  raw asynchronous button; scrolls the window toward less-significant digits.
- `disp0`..`disp3`  in  4 each  digit codes from the view stage; `disp0` is rightmost.
- `view_mode`  out  2  window select to the view stage; range 00..10.
- `an`  out  4  anode enables, active-low one-hot; bit 0 is the rightmost digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Button path, per button, via sub-module `btn_debounce`:
  - 2-flop synchronizer into `sync`.
  - If `sync == db`, counter clears.
  - Else if counter == `DEBOUNCE_CYCLES-1`, `db <= sync` and counter clears.
  - Else counter increments.
  - Press pulse = `db & ~db_d`, where `db_d` is `db` delayed one cycle. Releases generate nothing.
- View register:
  - Left pulse only: `view_mode` increments, saturating at 10.
  - Right pulse only: `view_mode` decrements, saturating at 00.
  - Both pulses in the same cycle: no change.
  - Value 11 is never produced.
- Scanner:
  - Refresh counter runs 0..`REFRESH_DIV-1` and wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - Each cycle, `an` is registered to the active-low one-hot of the index, and `seg` to the decode of `disp[index]`.
- Decode:
  - 0–9: standard glyphs.
  - 4'hA: minus (g only, `seg` = 7'b0111111).
  - 4'hB–4'hF: blank (7'h7F).
- `dp` is driven low only when index == 0 and `view_mode != 00`, to flag that the window is shifted. Otherwise `dp` is high.

## Timing
- Reset values (while `rst_n` is sampled low):
  - `view_mode` = 00, `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1.
  - Refresh counter, digit index, debounce counters, synchronizers, `db` and `db_d` all 0.
- Reset asserted mid-operation clears everything on the same edge. Any press in flight is discarded.
- First edge after reset release: `an` = 4'b1110 with digit 0 decoded.
- Each digit is lit for exactly `REFRESH_DIV` cycles. Full scan period is 4×`REFRESH_DIV`.
- `disp*` change → `seg` reflects it 1 cycle later, if that digit is selected.
- Press latency: raw level stable from edge 0 → `db` rises at edge `DEBOUNCE_CYCLES+2` → `view_mode` updates at edge `DEBOUNCE_CYCLES+3`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles causes no change, and its counter restarts.
- Holding a button produces one step only.

## Structure
- Package `seg_view_pkg` holds:
  - `VIEW_MIN` = 2'b00, `VIEW_MAX` = 2'b10.
  - Digit codes `CODE_MINUS` = 4'hA, `CODE_BLANK` = 4'hF.
  - The 16-entry segment lookup constant and the `SEG_OFF` = 7'h7F constant.
- One sub-module, `btn_debounce` (synchronizer + counter + `db`/`db_d` + press pulse), instantiated twice.
- The scanner and view register live in the top.

## Test plan
Parameters: `DEBOUNCE_CYCLES=4`, `REFRESH_DIV=3`.
- Reset then release with `disp0..3` = 1,2,3,4 → `an` = 1110/1101/1011/0111, each for 3 cycles, `seg` = glyphs 1,2,3,4, `dp` = 1; during reset all outputs are at their reset values.
- `btn_left` held high from edge 0 → `view_mode` = 01 at edge 7 and stays 01 while held. Release, then two more presses → 10, 10 (saturation).
- At `view_mode` = 00, press `btn_right` → stays 00. Left and right pulses in the same cycle at 01 → stays 01.
- `btn_left` high for 3 cycles, then low → `view_mode` unchanged (glitch rejected).
- `disp3` = 4'hA, `disp2` = 4'hF, `view_mode` = 10 → digit 3 `seg` = 7'b0111111, digit 2 `seg` = 7'h7F, `dp` low only while `an` = 1110.
- Assert `rst_n` low mid-scan with `view_mode` = 10 and a press half-debounced → next edge: `view_mode` = 00, `an` = 1111. After release, the scan restarts at digit 0 and no stale step occurs.
